// File: rtl/pipe_reg.sv
// Elastic DEPTH-stage pipeline register with valid/ready handshake, flush and occupancy count.
// Optional per-stage parity bit when PIPE_REG_PARITY_EN is defined.
module pipe_reg #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count,
  input  logic                       err_inj,
  output logic                       out_perr
);

  localparam int CW = $clog2(DEPTH+1);

  logic [DEPTH-1:0] v_reg;
  logic [WIDTH-1:0] d_reg [DEPTH];
  logic [CW-1:0]    count_reg;

  logic [DEPTH-1:0] adv;
  logic [DEPTH-1:0] src_v;
  logic [WIDTH-1:0] src_d [DEPTH];
  logic             accept;
  logic             deliver;

  // A stage may advance if it is empty or everything downstream of it moves.
  always_comb begin
    adv = '0;
    adv[DEPTH-1] = !v_reg[DEPTH-1] | out_ready;
    for (int i = DEPTH-2; i >= 0; i--) begin
      adv[i] = !v_reg[i] | adv[i+1];
    end
  end

  assign in_ready = adv[0] & !flush;
  assign accept   = in_valid & in_ready;
  assign deliver  = v_reg[DEPTH-1] & out_ready;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_src
      if (gi == 0) begin : g_first
        assign src_v[gi] = accept;
        assign src_d[gi] = in_data;
      end else begin : g_chain
        assign src_v[gi] = v_reg[gi-1];
        assign src_d[gi] = d_reg[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      v_reg     <= '0;
      count_reg <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        d_reg[i] <= '0;
      end
    end else if (flush) begin
      v_reg     <= '0;
      count_reg <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (adv[i]) begin
          v_reg[i] <= src_v[i];
          if (src_v[i]) begin
            d_reg[i] <= src_d[i];
          end
        end
      end
      case ({accept, deliver})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign out_valid = v_reg[DEPTH-1];
  assign out_data  = d_reg[DEPTH-1];
  assign count     = count_reg;

`ifdef PIPE_REG_PARITY_EN
  logic [DEPTH-1:0] p_reg;
  logic [DEPTH-1:0] src_p;

  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_psrc
      if (gi == 0) begin : g_first
        assign src_p[gi] = (^in_data) ^ err_inj;
      end else begin : g_chain
        assign src_p[gi] = p_reg[gi-1];
      end
    end
  endgenerate

  // Parity travels with the data word; flush leaves it untouched like the data.
  always_ff @(posedge clk) begin
    if (rst) begin
      p_reg <= '0;
    end else if (!flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (adv[i] && src_v[i]) begin
          p_reg[i] <= src_p[i];
        end
      end
    end
  end

  assign out_perr = out_valid & (p_reg[DEPTH-1] != (^out_data));
`else
  logic unused_err_inj;
  assign unused_err_inj = err_inj;
  assign out_perr       = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_reg.sv
// Directed bench for pipe_reg (WIDTH=32, DEPTH=2): table of handshake vectors plus
// hand-written reset, mid-stream reset and parity sequences.
module tb_pipe_reg;

  localparam int WIDTH = 32;
  localparam int DEPTH = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic [1:0]       count;
  logic             err_inj;
  logic             out_perr;

  int checks = 0;
  int errors = 0;

  pipe_reg #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .count     (count),
    .err_inj   (err_inj),
    .out_perr  (out_perr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [31:0] id;
    logic        ordy;
    logic        fl;
    logic        e_ir;
    logic        e_ov;
    logic [31:0] e_od;
    logic [1:0]  e_cnt;
  } vec_t;

  vec_t vecs [20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive inputs on the falling edge and sample outputs 1ns later.
  task automatic drive(input logic iv, input logic [31:0] id, input logic ordy,
                       input logic fl, input logic ei);
    @(negedge clk);
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    flush     = fl;
    err_inj   = ei;
    #1;
  endtask

  initial begin
    // Streaming at full rate, out_ready=1
    vecs[0]  = '{1'b1, 32'h11, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,  2'd0};
    vecs[1]  = '{1'b1, 32'h22, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,  2'd1};
    vecs[2]  = '{1'b1, 32'h33, 1'b1, 1'b0, 1'b1, 1'b1, 32'h11, 2'd2};
    vecs[3]  = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b1, 32'h22, 2'd2};
    vecs[4]  = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b1, 32'h33, 2'd1};
    vecs[5]  = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b0, 32'h0,  2'd0};
    // Fill with out_ready=0 until back-pressure, then drain
    vecs[6]  = '{1'b1, 32'h44, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,  2'd0};
    vecs[7]  = '{1'b1, 32'h55, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,  2'd1};
    vecs[8]  = '{1'b1, 32'h66, 1'b0, 1'b0, 1'b0, 1'b1, 32'h44, 2'd2};
    vecs[9]  = '{1'b1, 32'h66, 1'b0, 1'b0, 1'b0, 1'b1, 32'h44, 2'd2};
    vecs[10] = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b1, 32'h44, 2'd2};
    vecs[11] = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b1, 32'h55, 2'd1};
    vecs[12] = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b0, 32'h0,  2'd0};
    // Full pipe, flush with a concurrent in beat, then a fresh beat
    vecs[13] = '{1'b1, 32'h71, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,  2'd0};
    vecs[14] = '{1'b1, 32'h72, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,  2'd1};
    vecs[15] = '{1'b1, 32'h73, 1'b0, 1'b1, 1'b0, 1'b1, 32'h71, 2'd2};
    vecs[16] = '{1'b1, 32'hAA, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,  2'd0};
    vecs[17] = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b0, 32'h0,  2'd1};
    vecs[18] = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b1, 32'hAA, 2'd1};
    vecs[19] = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b0, 32'h0,  2'd0};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0;
    out_ready = 1'b0; err_inj = 1'b0;

    // Reset held two cycles then released
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_count",     {30'b0, count},     32'd0);
    chk("rst_in_ready",  {31'b0, in_ready},  32'd1);
    chk("rst_out_data",  out_data,           32'd0);
    chk("rst_out_perr",  {31'b0, out_perr},  32'd0);
    $display("reset: out_valid=%0b count=%0d in_ready=%0b out_data=0x%0h",
             out_valid, count, in_ready, out_data);

    for (int i = 0; i < 20; i++) begin
      drive(vecs[i].iv, vecs[i].id, vecs[i].ordy, vecs[i].fl, 1'b0);
      $display("vec %0d: iv=%0b id=0x%0h ordy=%0b fl=%0b -> ir=%0b ov=%0b od=0x%0h cnt=%0d",
               i, vecs[i].iv, vecs[i].id, vecs[i].ordy, vecs[i].fl,
               in_ready, out_valid, out_data, count);
      chk($sformatf("vec%0d_in_ready", i),  {31'b0, in_ready},  {31'b0, vecs[i].e_ir});
      chk($sformatf("vec%0d_out_valid", i), {31'b0, out_valid}, {31'b0, vecs[i].e_ov});
      chk($sformatf("vec%0d_count", i),     {30'b0, count},     {30'b0, vecs[i].e_cnt});
      chk($sformatf("vec%0d_out_perr", i),  {31'b0, out_perr},  32'd0);
      if (vecs[i].e_ov)
        chk($sformatf("vec%0d_out_data", i), out_data, vecs[i].e_od);
    end

    // Reset with two beats in flight
    drive(1'b1, 32'hB1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'hB2, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 32'h0,  1'b0, 1'b0, 1'b0);
    chk("midrst_full_count", {30'b0, count}, 32'd2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    $display("midstream reset: out_valid=%0b count=%0d out_data=0x%0h", out_valid, count, out_data);
    chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("midrst_count",     {30'b0, count},     32'd0);
    chk("midrst_out_data",  out_data,           32'd0);
    chk("midrst_in_ready",  {31'b0, in_ready},  32'd1);
    for (int i = 0; i < 2*DEPTH; i++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      $display("post-reset cycle %0d: out_valid=%0b count=%0d", i, out_valid, count);
      chk($sformatf("midrst_stale%0d", i), {31'b0, out_valid}, 32'd0);
    end

    // Parity: 0x5 with injected error, then 0x5 clean
    drive(1'b1, 32'h5, 1'b1, 1'b0, 1'b1);
    drive(1'b1, 32'h5, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    $display("parity beat 0: out_valid=%0b out_data=0x%0h out_perr=%0b", out_valid, out_data, out_perr);
    chk("par0_out_valid", {31'b0, out_valid}, 32'd1);
    chk("par0_out_data",  out_data,           32'h5);
`ifdef PIPE_REG_PARITY_EN
    chk("par0_out_perr",  {31'b0, out_perr},  32'd1);
`else
    chk("par0_out_perr",  {31'b0, out_perr},  32'd0);
`endif
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    $display("parity beat 1: out_valid=%0b out_data=0x%0h out_perr=%0b", out_valid, out_data, out_perr);
    chk("par1_out_valid", {31'b0, out_valid}, 32'd1);
    chk("par1_out_data",  out_data,           32'h5);
    chk("par1_out_perr",  {31'b0, out_perr},  32'd0);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("par_drained", {31'b0, out_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
